// File: rtl/alu_issue_buffer_if.sv
// Bus bundle between the issue stage / ALU controller side (master) and alu_issue_buffer (slave).
interface alu_issue_buffer_if #(
    parameter int PTR_WIDTH  = 2,
    parameter int WFID_WIDTH = 6
);
    logic                  in_issue_valid;
    logic [31:0]           in_opcode;
    logic [11:0]           in_source1_addr;
    logic [11:0]           in_source2_addr;
    logic [11:0]           in_source3_addr;
    logic [11:0]           in_dest1_addr;
    logic [11:0]           in_dest2_addr;
    logic [WFID_WIDTH-1:0] in_wfid;
    logic                  out_issue_ready;
    logic                  in_alu_ready;
    logic                  in_instr_done;
    logic                  out_alu_select;
    logic                  out_alu_select_flopped;
    logic [31:0]           out_opcode;
    logic [11:0]           out_source1_addr;
    logic [11:0]           out_source2_addr;
    logic [11:0]           out_source3_addr;
    logic [11:0]           out_dest1_addr;
    logic [11:0]           out_dest2_addr;
    logic                  out_done_valid;
    logic [WFID_WIDTH-1:0] out_done_wfid;
    logic [PTR_WIDTH:0]    out_occupancy;
    logic                  out_spurious_done;

    modport master (
        output in_issue_valid, in_opcode,
        output in_source1_addr, in_source2_addr, in_source3_addr,
        output in_dest1_addr, in_dest2_addr, in_wfid,
        output in_alu_ready, in_instr_done,
        input  out_issue_ready, out_alu_select, out_alu_select_flopped,
        input  out_opcode, out_source1_addr, out_source2_addr, out_source3_addr,
        input  out_dest1_addr, out_dest2_addr,
        input  out_done_valid, out_done_wfid, out_occupancy, out_spurious_done
    );

    modport slave (
        input  in_issue_valid, in_opcode,
        input  in_source1_addr, in_source2_addr, in_source3_addr,
        input  in_dest1_addr, in_dest2_addr, in_wfid,
        input  in_alu_ready, in_instr_done,
        output out_issue_ready, out_alu_select, out_alu_select_flopped,
        output out_opcode, out_source1_addr, out_source2_addr, out_source3_addr,
        output out_dest1_addr, out_dest2_addr,
        output out_done_valid, out_done_wfid, out_occupancy, out_spurious_done
    );
endinterface

// File: rtl/alu_issue_buffer.sv
// ALU instruction queue feeding the ALU controller one instruction at a time.
// Optional macro ALU_ISSUE_BYPASS_EN: empty idle buffer launches an offered instruction directly.
module alu_issue_buffer #(
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2,
    parameter int WFID_WIDTH = 6
) (
    input logic              clk,
    input logic              rst,
    alu_issue_buffer_if.slave bus
);

    typedef struct packed {
        logic [31:0]           opcode;
        logic [11:0]           src1;
        logic [11:0]           src2;
        logic [11:0]           src3;
        logic [11:0]           dst1;
        logic [11:0]           dst2;
        logic [WFID_WIDTH-1:0] wfid;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] ONE  = (PTR_WIDTH+1)'(1);

    state_t                state_q;
    state_t                state_d;
    entry_t                mem [DEPTH];
    entry_t                in_entry;
    entry_t                held;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH:0]    occ;
    logic                  issue_ready;
    logic                  push;
    logic                  pop;
    logic                  bypass;
    logic                  launch;
    logic                  alu_select_q;
    logic                  alu_select_flopped_q;
    logic                  done_valid_q;
    logic [WFID_WIDTH-1:0] done_wfid_q;
    logic                  spurious_q;

    always_comb begin
        in_entry.opcode = bus.in_opcode;
        in_entry.src1   = bus.in_source1_addr;
        in_entry.src2   = bus.in_source2_addr;
        in_entry.src3   = bus.in_source3_addr;
        in_entry.dst1   = bus.in_dest1_addr;
        in_entry.dst2   = bus.in_dest2_addr;
        in_entry.wfid   = bus.in_wfid;
    end

    // Ready depends only on stored occupancy, so a pop in the same cycle never frees a slot early.
    assign issue_ready = (occ != FULL);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (occ != '0 && bus.in_alu_ready) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
`ifdef ALU_ISSUE_BYPASS_EN
                else if (occ == '0 && bus.in_alu_ready && bus.in_issue_valid) begin
                    bypass  = 1'b1;
                    state_d = ISSUE;
                end
`endif
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.in_instr_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push   = bus.in_issue_valid && issue_ready && !bypass;
    assign launch = pop || bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + ONE;
                2'b01:   occ <= occ - ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held                 <= '0;
            alu_select_q         <= 1'b0;
            alu_select_flopped_q <= 1'b0;
            done_valid_q         <= 1'b0;
            done_wfid_q          <= '0;
            spurious_q           <= 1'b0;
        end else begin
            if (pop) begin
                held <= mem[rd_ptr];
            end else if (bypass) begin
                held <= in_entry;
            end
            alu_select_q         <= launch;
            alu_select_flopped_q <= alu_select_q;
            done_valid_q         <= (state_q == WAIT) && bus.in_instr_done;
            if ((state_q == WAIT) && bus.in_instr_done) begin
                done_wfid_q <= held.wfid;
            end
            if ((state_q != WAIT) && bus.in_instr_done) begin
                spurious_q <= 1'b1;
            end
        end
    end

    assign bus.out_issue_ready        = issue_ready;
    assign bus.out_alu_select         = alu_select_q;
    assign bus.out_alu_select_flopped = alu_select_flopped_q;
    assign bus.out_opcode             = held.opcode;
    assign bus.out_source1_addr       = held.src1;
    assign bus.out_source2_addr       = held.src2;
    assign bus.out_source3_addr       = held.src3;
    assign bus.out_dest1_addr         = held.dst1;
    assign bus.out_dest2_addr         = held.dst2;
    assign bus.out_done_valid         = done_valid_q;
    assign bus.out_done_wfid          = done_wfid_q;
    assign bus.out_occupancy          = occ;
    assign bus.out_spurious_done      = spurious_q;

endmodule
